// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_pkg
//  Description : Shared types and constants for the nibble-serial wide
//                adder/subtractor: controller state encoding and the width
//                of one nibble slice.
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Width of one slice handed to adder_4bit.
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_4bit
//  Description : Combinational 4-bit ripple adder with carry in and carry out.
//  Ports       : a, b  - 4-bit addends
//                cin   - carry in
//                sum   - 4-bit sum
//                cout  - carry out of bit 3
//  Revision    : 1.0  initial release
// ============================================================================
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum  = full[3:0];
  assign cout = full[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor built around one
//                adder_4bit. Operands are accepted in IDLE, processed one
//                nibble per clock (LSB first) in RUN with a registered ripple
//                carry, and the assembled result is presented in DONE until
//                the consumer takes it.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid / in_ready - operand handshake
//                a, b, cin, sub      - operands, carry in, subtract select
//                out_valid/out_ready - result handshake
//                sum, cout, ovf      - result, carry out, signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // b already inverted for subtraction
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  adder_4bit u_adder_4bit (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle publishes the result; the output registers then
        // hold it until the consumer accepts and on through IDLE.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          sum_d       = res_q;
          cout_d      = carry_q;
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (res_q[WIDTH-1] != a_q[WIDTH-1]);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder (WIDTH=16) with
//                a scoreboard queue of expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int LAT = 5;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks;
  int   failures;
  exp_t sb[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t         e;
    logic [W:0]   full;
    if (s) begin
      e.sum  = x - y;
      e.cout = (x >= y);
      e.ovf  = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    end else begin
      full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    end
    return e;
  endfunction

  // Presents one operand set for exactly one edge and records the expectation.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s, output logic rdy);
    @(negedge clk);
    rdy      = in_ready;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = s;
    in_valid = 1'b1;
    sb.push_back(model(x, y, ci, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, bounded.
  task automatic wait_out(output int lat, output bit timed_out);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = (out_valid !== 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", cout, ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string tag, input logic [W-1:0] xs[4],
                              input logic [W-1:0] ys[4], input logic cs[4],
                              input logic ss[4], input int n);
    logic rdy;
    int   lat;
    bit   to;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive_op(xs[i], ys[i], cs[i], ss[i], rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL %s[%0d]_in_ready got=%b exp=1", tag, i, rdy); end
      wait_out(lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin
        failures++; $display("FAIL %s[%0d]_timeout out_valid never rose", tag, i);
      end else if (lat != LAT) begin
        failures++; $display("FAIL %s[%0d]_latency got=%0d exp=%0d", tag, i, lat, LAT);
      end
      checks++; if (sum !== e.sum) begin failures++; $display("FAIL %s[%0d]_sum got=%h exp=%h", tag, i, sum, e.sum); end
      checks++; if (cout !== e.cout) begin failures++; $display("FAIL %s[%0d]_cout got=%b exp=%b", tag, i, cout, e.cout); end
      checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL %s[%0d]_ovf got=%b exp=%b", tag, i, ovf, e.ovf); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL %s[%0d]_return got=v%b r%b exp=v0 r1", tag, i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_add;
    logic [W-1:0] xs[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [W-1:0] ys[4] = '{16'h1111, 16'h0001, 16'h0000, 16'h0000};
    logic         cs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         ss[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    test_vectors("add", xs, ys, cs, ss, 3);
  endtask

  task automatic test_sub;
    logic [W-1:0] xs[4] = '{16'h0005, 16'h8000, 16'h1234, 16'h0000};
    logic [W-1:0] ys[4] = '{16'h0007, 16'h0001, 16'h1234, 16'h0000};
    logic         cs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic         ss[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    test_vectors("sub", xs, ys, cs, ss, 3);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic         cs[4];
    logic         ss[4];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = W'($urandom);
        ys[i] = W'($urandom);
        cs[i] = 1'($urandom);
        ss[i] = 1'($urandom);
      end
      test_vectors("rand", xs, ys, cs, ss, 4);
    end
  endtask

  task automatic test_backpressure;
    logic rdy;
    int   lat;
    bit   to;
    exp_t e;
    logic [W-1:0] held;
    out_ready = 1'b0;
    drive_op(16'h89AB, 16'h7654, 1'b1, 1'b0, rdy);
    wait_out(lat, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL bp_timeout out_valid never rose"); end
    checks++; if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      failures++; $display("FAIL bp_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    held = e.sum;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      sub      = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]_hs got=v%b r%b exp=v1 r0", i, out_valid, in_ready);
      end
      checks++; if (sum !== held || cout !== e.cout || ovf !== e.ovf) begin
        failures++; $display("FAIL bp_hold[%0d]_data got=%h/%b/%b exp=%h/%b/%b", i, sum, cout, ovf, held, e.cout, e.ovf);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    checks++; if (sum !== held) begin failures++; $display("FAIL bp_idle_sum got=%h exp=%h", sum, held); end
    // The operands offered during DONE must not have started a new operation.
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_no_accept got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic rdy;
    int   lat;
    bit   to;
    exp_t e;
    drive_op(16'h1234, 16'h4321, 1'b0, 1'b0, rdy);
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid got=v%b s%h r%b exp=v0 s0000 r1", out_valid, sum, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_op(16'h0001, 16'h0001, 1'b0, 1'b0, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rst_after_in_ready got=%b exp=1", rdy); end
    wait_out(lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != LAT) begin failures++; $display("FAIL rst_after_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      failures++; $display("FAIL rst_after_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
